// File: rtl/pdm_mic_capture.sv
// PDM microphone front end: drives mic_clk, synchronises mic_data, packs DW-bit words
// and strobes them into the downstream sample FIFO, counting words dropped on overflow.
module pdm_mic_capture #(
    parameter int CLK_DIV = 25,
    parameter int WARMUP  = 1024,
    parameter int DW      = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic          mic_data,
    input  logic          full,
    output logic          mic_clk,
    output logic          mic_lr,
    output logic [DW-1:0] dout,
    output logic          wr,
    output logic [15:0]   overflow_cnt,
    output logic [1:0]    state
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_RUN    = 2'd2
    } state_t;

    localparam int DIV_W  = $clog2(CLK_DIV);
    localparam int WARM_W = $clog2(WARMUP + 1);
    localparam int BIT_W  = $clog2(DW + 1);

    state_t              state_q, state_d;
    logic                sync1_q, sd_q;
    logic                mic_clk_q, mic_clk_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [WARM_W-1:0]   warm_cnt_q, warm_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DW-1:0]       shreg_q, shreg_d;
    logic [DW-1:0]       dout_q, dout_d;
    logic                wr_q, wr_d;
    logic [15:0]         overflow_cnt_q, overflow_cnt_d;

    logic                div_tc;
    logic                capture_edge;
    logic [DW-1:0]       shreg_next;

    assign div_tc       = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    // The mic drives data while mic_clk is high; we take it as mic_clk is registered low.
    assign capture_edge = div_tc && mic_clk_q;
    assign shreg_next   = (shreg_q << 1) | DW'(sd_q);

    // NOTE: every variable gets its default first so no path through the block infers a latch.
    always_comb begin
        state_d        = state_q;
        mic_clk_d      = mic_clk_q;
        div_cnt_d      = div_cnt_q;
        warm_cnt_d     = warm_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        shreg_d        = shreg_q;
        dout_d         = dout_q;
        wr_d           = 1'b0;
        overflow_cnt_d = overflow_cnt_q;

        case (state_q)
            S_IDLE: begin
                mic_clk_d  = 1'b0;
                div_cnt_d  = '0;
                warm_cnt_d = '0;
                bit_cnt_d  = '0;
                shreg_d    = '0;
                if (enable) state_d = S_WARMUP;
            end
            S_WARMUP, S_RUN: begin
                if (div_tc) begin
                    div_cnt_d = '0;
                    mic_clk_d = ~mic_clk_q;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end

                if (capture_edge && state_q == S_WARMUP) begin
                    warm_cnt_d = warm_cnt_q + WARM_W'(1);
                    if (warm_cnt_q == WARM_W'(WARMUP - 1)) state_d = S_RUN;
                end

                if (capture_edge && state_q == S_RUN) begin
                    shreg_d = shreg_next;
                    if (bit_cnt_q == BIT_W'(DW - 1)) begin
                        bit_cnt_d = '0;
                        if (!full) begin
                            dout_d = shreg_next;
                            wr_d   = 1'b1;
                        end else if (overflow_cnt_q != 16'hFFFF) begin
                            overflow_cnt_d = overflow_cnt_q + 16'd1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Disabling abandons any partial word but keeps the last delivered word and the drop count.
        if (!enable) begin
            state_d        = S_IDLE;
            mic_clk_d      = 1'b0;
            div_cnt_d      = '0;
            warm_cnt_d     = '0;
            bit_cnt_d      = '0;
            shreg_d        = '0;
            wr_d           = 1'b0;
            dout_d         = dout_q;
            overflow_cnt_d = overflow_cnt_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            sync1_q        <= 1'b0;
            sd_q           <= 1'b0;
            mic_clk_q      <= 1'b0;
            div_cnt_q      <= '0;
            warm_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            shreg_q        <= '0;
            dout_q         <= '0;
            wr_q           <= 1'b0;
            overflow_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= mic_data;
            sd_q           <= sync1_q;
            mic_clk_q      <= mic_clk_d;
            div_cnt_q      <= div_cnt_d;
            warm_cnt_q     <= warm_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shreg_q        <= shreg_d;
            dout_q         <= dout_d;
            wr_q           <= wr_d;
            overflow_cnt_q <= overflow_cnt_d;
        end
    end

    assign mic_clk      = mic_clk_q;
    assign mic_lr       = 1'b0;
    assign dout         = dout_q;
    assign wr           = wr_q;
    assign overflow_cnt = overflow_cnt_q;
    assign state        = state_q;

endmodule

// File: doc/pdm_mic_capture.md
# pdm_mic_capture

PDM microphone front end for the PCM audio capture path. It generates the microphone bit clock and synchronises the mic's 1-bit PDM data into the system clock domain. It packs the samples into DW-bit words and issues single-cycle write strobes to the downstream sample FIFO. The block discards the mic's power-up interval, honours the FIFO `full` flag, and counts samples dropped on overflow.

## Interface
- CLK_DIV, default 25: system clocks per mic_clk half-period; legal range ≥2. 100 MHz / 50 gives a 2 MHz mic clock.
- WARMUP, default 1024: mic_clk periods discarded after enable before capture starts; legal range ≥1.
- DW, default 1: word width delivered to the FIFO; must equal the FIFO `dbits`.
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high.
- enable  in  1  level; 1 = run the microphone and capture, 0 = stop.
- mic_data  in  1  PDM data from the microphone (asynchronous).
- full  in  1  FIFO full flag.
- mic_clk  out  1  registered bit clock to the microphone.
- mic_lr  out  1  constant 0; selects the left channel, data valid while mic_clk is high.
- dout  out  DW  packed word to the FIFO `din`.
- wr  out  1  write strobe to the FIFO `wr`; one-cycle pulse.
- overflow_cnt  out  16  count of words dropped because `full` was high; saturates at 65535.
- state  out  2  current state: 0 IDLE, 1 WARMUP, 2 RUN.

## Operation
- mic_data passes through a 2-flop synchroniser; `sd` is the second flop.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 while in WARMUP or RUN.
  - At terminal count, mic_clk toggles and div_cnt returns to 0.
  - A "capture edge" is the cycle in which mic_clk is registered from 1 to 0.
- IDLE:
  - mic_clk = 0, div_cnt = 0, warm_cnt = 0, bit_cnt = 0, wr = 0.
  - enable = 1 moves to WARMUP on the next cycle.
- WARMUP:
  - The divider runs and each capture edge increments warm_cnt.
  - On the capture edge that makes warm_cnt reach WARMUP, the state moves to RUN. No sample is taken on that edge.
- RUN, on each capture edge:
  - shreg <= {shreg[DW-2:0], sd}, with the new bit entering at the LSB; for DW=1, shreg <= sd.
  - bit_cnt increments.
  - When bit_cnt reaches DW, bit_cnt returns to 0 and a word is complete:
    - if full = 0: dout <= the completed word (including the bit just captured) and wr <= 1 for exactly one cycle.
    - if full = 1: wr stays 0, dout is unchanged, and overflow_cnt increments with saturation at 65535.
- enable = 0 in any state:
  - Next cycle the state is IDLE and mic_clk is 0.
  - Any partial word is discarded. A wr already asserted in that cycle is cleared.
  - dout and overflow_cnt are retained.
- Re-enabling always passes through WARMUP again.

## Timing
- Reset values: mic_clk 0, mic_lr 0, dout 0, wr 0, overflow_cnt 0, state IDLE, and all counters 0.
- Reset mid-operation clears everything immediately, because reset is asynchronous.
- mic_clk period is 2·CLK_DIV system clocks with 50% duty.
- The first rising edge of mic_clk occurs CLK_DIV cycles after entering WARMUP.
- mic_data to sample latency: 2 synchroniser cycles before the capture edge. The data sampled is sd as registered at the capture edge.
- wr is registered and rises in the same cycle dout is updated.
- Strobe spacing is 2·CLK_DIV·DW cycles. This guarantees wr is low for ≥3 cycles between pulses, as the FIFO's edge detector requires.
- dout is held stable until the next word, which is ≥4 cycles; this covers the FIFO's 3-cycle write delay after wr.
- full is sampled only in the word-completion cycle.
- First possible wr: (2·WARMUP + 2·DW)·CLK_DIV cycles after enable rises, ±1 cycle.

## Test plan
- Reset, then CLK_DIV=4, WARMUP=3, DW=1, enable=1, mic_data=1 constant:
  - mic_clk toggles every 4 cycles.
  - The first wr comes after exactly 3 discarded capture edges, with dout=1.
  - wr then pulses every 8 cycles.
- DW=4, mic_data driven 1,0,1,1 aligned to successive capture edges:
  - dout=4'b1011, with one wr pulse per 32 cycles.
  - overflow_cnt remains 0.
- full=1 held for 5 word completions (DW=1):
  - wr stays 0 and overflow_cnt = 5.
  - full released → the next word is written normally.
- Force overflow_cnt to 65534, then hold full for 3 words: overflow_cnt saturates at 65535.
- enable dropped mid-word (DW=4, after 2 bits):
  - mic_clk = 0 and state = IDLE the next cycle, with no wr.
  - Re-enable → WARMUP repeats and the next word contains only new bits.
- Reset asserted in RUN while wr=1: wr, mic_clk and dout go to 0 immediately; after release, state = IDLE.
